// File: rtl/traffic_request_frontend_if.sv
// Signal bundle between the board-side sensors/controller and the request front end.
// The master side drives raw sensors, light state and grants; the slave side drives requests.
interface traffic_request_frontend_if;
  logic       btn_NS;
  logic       btn_EW;
  logic       siren_NS;
  logic       siren_EW;
  logic [1:0] light_NS;
  logic [1:0] light_EW;
  logic       pred_signal_NS;
  logic       pred_signal_EW;
  logic       pred_NS;
  logic       pred_EW;
  logic       emergency_NS;
  logic       emergency_EW;
  logic       wait_NS;
  logic       wait_EW;
  logic       req_stuck_NS;
  logic       req_stuck_EW;
  logic       conflict_err;

  modport master (
    output btn_NS, btn_EW, siren_NS, siren_EW,
    output light_NS, light_EW, pred_signal_NS, pred_signal_EW,
    input  pred_NS, pred_EW, emergency_NS, emergency_EW,
    input  wait_NS, wait_EW, req_stuck_NS, req_stuck_EW, conflict_err
  );

  modport slave (
    input  btn_NS, btn_EW, siren_NS, siren_EW,
    input  light_NS, light_EW, pred_signal_NS, pred_signal_EW,
    output pred_NS, pred_EW, emergency_NS, emergency_EW,
    output wait_NS, wait_EW, req_stuck_NS, req_stuck_EW, conflict_err
  );
endinterface

// File: rtl/traffic_request_frontend.sv
// Cleans raw pedestrian/emergency inputs into controller request levels, closes the
// pedestrian grant handshake, arbitrates emergencies and flags conflicting lights.
module traffic_request_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REQ_TIMEOUT     = 256
) (
  input  logic                         clk,
  input  logic                         reset_n,
  traffic_request_frontend_if.slave    bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = $clog2(REQ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(REQ_TIMEOUT);

  typedef enum logic [1:0] {P_IDLE, P_REQ, P_SERV} ped_state_e;
  typedef enum logic [1:0] {O_NONE, O_NS, O_EW}    owner_e;

  // Channel order: 0 btn_NS, 1 btn_EW, 2 siren_NS, 3 siren_EW
  logic [3:0] raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] deb;
  logic [1:0] grant;
  logic [1:0] pred_v;
  logic [1:0] stuck_v;

  assign raw   = {bus.siren_EW, bus.siren_NS, bus.btn_EW, bus.btn_NS};
  assign grant = {bus.pred_signal_EW, bus.pred_signal_NS};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < 4; ch++) begin : g_deb
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q[ch] == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q[ch];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb[ch] = deb_q;
  end

  for (genvar d = 0; d < 2; d++) begin : g_ped
    ped_state_e       state_q;
    ped_state_e       state_d;
    logic             btn_prev_q;
    logic             btn_rise;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             pred_q;
    logic             pred_d;
    logic             stuck_q;
    logic             stuck_d;

    assign btn_rise = deb[d] & ~btn_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= P_IDLE;
        btn_prev_q <= 1'b0;
        tmr_q      <= '0;
        pred_q     <= 1'b0;
        stuck_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        btn_prev_q <= deb[d];
        tmr_q      <= tmr_d;
        pred_q     <= pred_d;
        stuck_q    <= stuck_d;
      end
    end

    // Presses seen outside IDLE are dropped rather than queued
    always_comb begin
      state_d = state_q;
      case (state_q)
        P_IDLE:  if (btn_rise)  state_d = P_REQ;
        P_REQ:   if (grant[d])  state_d = P_SERV;
        P_SERV:  if (!grant[d]) state_d = P_IDLE;
        default: state_d = P_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_comb begin
      pred_d = (state_d == P_REQ);
      tmr_d  = '0;
      if (state_d == P_REQ && state_q == P_REQ) begin
        tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
      end
      stuck_d = (state_d == P_REQ) && (tmr_d == TMR_MAX);
    end

    assign pred_v[d]  = pred_q;
    assign stuck_v[d] = stuck_q;
  end

  owner_e owner_q;
  owner_e owner_d;
  logic   em_ns_q;
  logic   em_ns_d;
  logic   em_ew_q;
  logic   em_ew_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= O_NONE;
      em_ns_q <= 1'b0;
      em_ew_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      em_ns_q <= em_ns_d;
      em_ew_q <= em_ew_d;
    end
  end

  // Owner hands straight over to the other siren when its own drops
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      O_NONE: begin
        if (deb[2])      owner_d = O_NS;
        else if (deb[3]) owner_d = O_EW;
      end
      O_NS: if (!deb[2]) owner_d = deb[3] ? O_EW : O_NONE;
      O_EW: if (!deb[3]) owner_d = deb[2] ? O_NS : O_NONE;
      default: owner_d = O_NONE;
    endcase
  end

  always_comb begin
    em_ns_d = (owner_d == O_NS);
    em_ew_d = (owner_d == O_EW);
  end

  logic conflict_q;
  logic conflict_d;

  assign conflict_d = conflict_q | ((bus.light_NS != 2'b00) && (bus.light_EW != 2'b00));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) conflict_q <= 1'b0;
    else          conflict_q <= conflict_d;
  end

  assign bus.pred_NS      = pred_v[0];
  assign bus.pred_EW      = pred_v[1];
  assign bus.wait_NS      = pred_v[0];
  assign bus.wait_EW      = pred_v[1];
  assign bus.req_stuck_NS = stuck_v[0];
  assign bus.req_stuck_EW = stuck_v[1];
  assign bus.emergency_NS = em_ns_q;
  assign bus.emergency_EW = em_ew_q;
  assign bus.conflict_err = conflict_q;

endmodule

// File: tb/tb_traffic_request_frontend.sv
// Directed bench for traffic_request_frontend with DEBOUNCE_CYCLES=4, REQ_TIMEOUT=16.
module tb_traffic_request_frontend;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  traffic_request_frontend_if bus ();

  traffic_request_frontend #(
    .DEBOUNCE_CYCLES(4),
    .REQ_TIMEOUT    (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] all_out();
    return {bus.pred_NS, bus.pred_EW, bus.wait_NS, bus.wait_EW,
            bus.emergency_NS, bus.emergency_EW, bus.req_stuck_NS,
            bus.req_stuck_EW, bus.conflict_err, 4'b0000};
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.btn_NS = 0; bus.btn_EW = 0; bus.siren_NS = 0; bus.siren_EW = 0;
    bus.light_NS = 2'b00; bus.light_EW = 2'b00;
    bus.pred_signal_NS = 0; bus.pred_signal_EW = 0;

    // Reset held while buttons toggle
    for (int i = 0; i < 6; i++) begin
      bus.btn_NS = ~bus.btn_NS;
      bus.btn_EW = (i % 3 == 0);
      tick();
    end
    chk("reset_outputs", 16'(all_out()), 16'h0);
    bus.btn_NS = 0; bus.btn_EW = 0;
    tick();
    reset_n = 1'b1;
    ticks(3);
    chk("post_release_outputs", 16'(all_out()), 16'h0);

    // Debounce latency: pred_NS rises after edge 6
    bus.btn_NS = 1;
    ticks(6);
    chk("pred_ns_before_edge6", 16'(bus.pred_NS), 16'h0);
    tick();
    chk("pred_ns_after_edge6", 16'(bus.pred_NS), 16'h1);
    chk("wait_ns_after_edge6", 16'(bus.wait_NS), 16'h1);

    // Stuck timer: sets 16 cycles after pred_NS rises
    ticks(15);
    chk("stuck_ns_at_15", 16'(bus.req_stuck_NS), 16'h0);
    tick();
    chk("stuck_ns_at_16", 16'(bus.req_stuck_NS), 16'h1);
    chk("pred_ns_while_stuck", 16'(bus.pred_NS), 16'h1);
    ticks(3);
    chk("stuck_ns_saturated", 16'(bus.req_stuck_NS), 16'h1);
    bus.pred_signal_NS = 1;
    tick();
    chk("stuck_ns_cleared_by_grant", 16'(bus.req_stuck_NS), 16'h0);
    chk("pred_ns_cleared_by_grant", 16'(bus.pred_NS), 16'h0);
    bus.pred_signal_NS = 0;
    bus.btn_NS = 0;
    ticks(8);

    // Glitches on btn_EW never reach the request
    bus.btn_EW = 1; ticks(3); bus.btn_EW = 0; ticks(10);
    chk("glitch3_ew", 16'(bus.pred_EW), 16'h0);
    bus.btn_EW = 1; ticks(1); bus.btn_EW = 0; ticks(10);
    chk("glitch1_ew", 16'(bus.pred_EW), 16'h0);

    // Clean press then a 40-cycle grant with a re-press inside it
    bus.btn_EW = 1;
    ticks(7);
    chk("pred_ew_clean_press", 16'(bus.pred_EW), 16'h1);
    bus.pred_signal_EW = 1;
    tick();
    chk("pred_ew_fall_on_grant", 16'(bus.pred_EW), 16'h0);
    bus.btn_EW = 0; ticks(10);
    bus.btn_EW = 1; ticks(10);
    chk("pred_ew_repress_in_grant", 16'(bus.pred_EW), 16'h0);
    ticks(19);
    chk("pred_ew_end_of_grant", 16'(bus.pred_EW), 16'h0);
    bus.pred_signal_EW = 0;
    ticks(4);
    chk("pred_ew_no_queueing", 16'(bus.pred_EW), 16'h0);
    bus.btn_EW = 0; ticks(8);
    bus.btn_EW = 1; ticks(7);
    chk("pred_ew_new_press_after_grant", 16'(bus.pred_EW), 16'h1);
    chk("wait_ew_new_press_after_grant", 16'(bus.wait_EW), 16'h1);
    bus.pred_signal_EW = 1; tick();
    bus.pred_signal_EW = 0; tick();
    bus.btn_EW = 0; ticks(8);
    chk("pred_ew_idle_again", 16'(bus.pred_EW), 16'h0);

    // Emergency arbitration: simultaneous sirens, NS wins, then handover
    bus.siren_NS = 1; bus.siren_EW = 1;
    ticks(6);
    chk("em_before_edge6", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h0);
    tick();
    chk("em_ns_wins_tie", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h2);
    bus.siren_NS = 0;
    ticks(6);
    chk("em_ns_holding", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h2);
    tick();
    chk("em_handover_same_edge", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h1);
    bus.siren_EW = 0;
    ticks(6);
    chk("em_ew_holding", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h1);
    tick();
    chk("em_both_released", 16'({bus.emergency_NS, bus.emergency_EW}), 16'h0);

    // Conflict monitor
    bus.light_NS = 2'b10; bus.light_EW = 2'b00;
    tick();
    chk("conflict_legal_green_red", 16'(bus.conflict_err), 16'h0);
    bus.light_EW = 2'b01;
    #1;
    chk("conflict_before_edge", 16'(bus.conflict_err), 16'h0);
    tick();
    chk("conflict_one_edge_later", 16'(bus.conflict_err), 16'h1);
    bus.light_NS = 2'b00; bus.light_EW = 2'b00;
    ticks(3);
    chk("conflict_sticky", 16'(bus.conflict_err), 16'h1);

    // Reset mid-request with an emergency owner
    bus.btn_NS = 1; bus.siren_EW = 1;
    ticks(7);
    chk("pred_ns_before_midreset", 16'(bus.pred_NS), 16'h1);
    chk("em_ew_before_midreset", 16'(bus.emergency_EW), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 16'(all_out()), 16'h0);
    bus.btn_NS = 0; bus.siren_EW = 0;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    chk("no_request_after_reset", 16'(all_out()), 16'h0);
    bus.btn_NS = 1;
    ticks(7);
    chk("new_press_after_reset", 16'(bus.pred_NS), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_frontend.md
# traffic_request_frontend

Request front end feeding `traffic_light_controller`. It turns raw pedestrian push-buttons and emergency-vehicle detectors into the clean request levels the controller consumes: `pred_NS`, `pred_EW`, `emergency_NS` and `emergency_EW`. It closes the pedestrian handshake using the controller's `pred_signal_NS`/`pred_signal_EW` grants, and monitors the controller's light outputs for conflicts. It sits between the board-level sensor pins and the controller, in the controller's clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its debounced value before the debounced value flips. Range is 1 or more.
- `REQ_TIMEOUT`, default 256: cycles a pedestrian request may wait ungranted before its stuck flag sets. Range is 2 or more.
- `clk`  in  1  system clock; all flops on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_NS`, `btn_EW`  in  1 each  raw pedestrian buttons; asynchronous and bouncy.
- `siren_NS`, `siren_EW`  in  1 each  raw emergency detectors; asynchronous and bouncy.
- `light_NS`, `light_EW`  in  2 each  controller light state; 00 RED, 01 YELLOW, 10 GREEN.
- `pred_signal_NS`, `pred_signal_EW`  in  1 each  controller pedestrian-walk grant.
- `pred_NS`, `pred_EW`  out  1 each  latched pedestrian request to the controller.
- `emergency_NS`, `emergency_EW`  out  1 each  emergency request; mutually exclusive.
- `wait_NS`, `wait_EW`  out  1 each  "WAIT" lamp; high while the request is pending.
- `req_stuck_NS`, `req_stuck_EW`  out  1 each  request pending at least `REQ_TIMEOUT` cycles.
- `conflict_err`  out  1  sticky; both directions were non-RED in the same cycle.

## Operation
- **Synchronizer:** each of the 4 raw inputs passes through a 2-flop synchronizer; the output is `s`.
- **Debounce:** per input, a register `deb` and a counter `cnt`, evaluated every edge:
  - if `s == deb`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= s`, `cnt <= 0`;
  - else: `cnt <= cnt+1`.
  - The counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit.
- **Pedestrian FSM**, one per direction, with states IDLE, REQ, SERVING:
  - IDLE to REQ on a rising edge of `deb_btn` (`deb` high, previous `deb` low).
  - REQ to SERVING when `pred_signal_X` is 1.
  - SERVING to IDLE when `pred_signal_X` is 0.
  - Button edges seen in REQ or SERVING are ignored; there is no queueing.
  - `pred_X` and `wait_X` are both registered and equal to (state == REQ).
  - A `pred_signal_X` that arrives while in IDLE is ignored.
- **Stuck timer:**
  - A per-direction counter counts cycles spent in REQ; it clears on entry to REQ and saturates at `REQ_TIMEOUT`.
  - `req_stuck_X` goes to 1 when the count reaches `REQ_TIMEOUT`.
  - `req_stuck_X` clears when the FSM leaves REQ.
  - `pred_X` stays asserted while stuck.
- **Emergency arbiter**, with owner states NONE, NS, EW:
  - From NONE, whichever `deb_siren` is high takes ownership. If both are high in the same cycle, NS wins.
  - The owner holds until its own `deb_siren` drops. At that edge the owner goes to the other direction if that siren is high, otherwise to NONE. There is no idle gap on handover.
  - `emergency_NS` is registered as (owner == NS); `emergency_EW` as (owner == EW). The two outputs are never both 1.
- **Conflict monitor:** `conflict_err` sets at the edge after a cycle with `light_NS != 00` and `light_EW != 00`. It clears only on reset.
- **Emergency priority:** pedestrian FSMs run independently of emergencies; prioritization is the controller's job.

## Timing
- **Reset:** asserting `reset_n` low immediately clears every flop.
  - All outputs go to 0, FSMs to IDLE, owner to NONE, all `deb`/`cnt`/sync flops to 0.
  - Reset asserted mid-request drops `pred_X` with no grant needed.
  - Deassertion is synchronized externally by the system; the block samples from the first rising edge after release.
- **Input latency:** a raw input first sampled high at edge 0 and held steady makes `deb` flip at edge `DEBOUNCE_CYCLES+1`.
  - `pred_X`, `wait_X` and `emergency_X` go high after edge `DEBOUNCE_CYCLES+2`, i.e. edge 6 with the default of 4.
  - Release latency is the same.
- **Glitch rejection:** a pulse lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles never reaches `deb`.
- **Handshake response:**
  - `pred_X` falls one edge after `pred_signal_X` is sampled high.
  - A new press is accepted only after `pred_signal_X` is seen low, which returns the FSM to IDLE.
- **Emergency handover:** NS drop with EW held means `emergency_NS` falls and `emergency_EW` rises on the same edge.
- **Conflict:** `conflict_err` lags the offending light state by 1 edge.

## Test plan
- **Reset and debounce:** hold `reset_n` low with buttons toggling, then release. Expect all outputs 0. Press `btn_NS` steady from edge 0 (`DEBOUNCE_CYCLES`=4). Expect `pred_NS` and `wait_NS` high after edge 6.
- **Glitch and grant:** send 3-cycle and 1-cycle `btn_EW` glitches. Expect `pred_EW` to stay 0. Then give a clean press followed by a 40-cycle `pred_signal_EW` pulse. Expect `pred_EW` low one edge after the grant, and a re-press during the grant to be ignored.
- **Stuck timer:** with `REQ_TIMEOUT`=16, press `btn_NS` and never grant. Expect `req_stuck_NS` high exactly 16 cycles after `pred_NS` rises. Then grant. Expect both `req_stuck_NS` and `pred_NS` to clear on the next edge.
- **Emergency arbitration:** assert `siren_NS` and `siren_EW` in the same cycle. Expect only `emergency_NS`. Drop `siren_NS`. Expect `emergency_EW` to rise on the same edge that `emergency_NS` falls. Drop `siren_EW`. Expect both outputs 0.
- **Conflict monitor:** drive `light_NS`=10 and `light_EW`=01 for 1 cycle. Expect `conflict_err`=1 one edge later, still 1 after the lights return legal, and 0 only after reset.
- **Reset mid-operation:** pull `reset_n` low while in REQ with an emergency owner active. Expect all outputs 0 asynchronously, and after release no request until a new debounced press.
